// File: rtl/adc_scan_serial.sv
// Scans NUM_CH channels of a 16-bit-frame SPI ADC on each sample pulse and emits one
// channel-tagged Avalon-ST beat per channel. Define ADC_SCAN_ADDR_CHECK_EN for address checking.
module adc_scan_serial #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12,
    parameter int CS_GAP = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample,
    input  logic              sdi,
    output logic              sdo,
    output logic              cs_n,
    output logic [DATA_W-1:0] ast_source_data,
    output logic [2:0]        ast_source_channel,
    output logic              ast_source_valid,
    output logic [1:0]        ast_source_error,
    output logic              busy
);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
`ifdef ADC_SCAN_ADDR_CHECK_EN
    localparam int RX_W = 14;
`else
    localparam int RX_W = 11;
`endif

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       bit_cnt, bit_nxt;
    logic [3:0]       frame_cnt, frame_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [RX_W-1:0]  rx;
    logic [RX_W:0]    rx_full;
    logic             ovr_flag;

    logic             gap_last, frame_last, frame_end, start;
    logic [2:0]       addr_nxt, chan;
    logic [15:0]      word_nxt;
    logic             cs_n_nxt, sdo_nxt, busy_nxt, beat, ovr_now, mismatch;

    function automatic logic [15:0] ctl_word(input logic [2:0] addr);
        return {3'b100, addr, 2'b11, 4'b0001, 4'b0000};
    endfunction

    assign gap_last   = (gap_cnt == GAP_W'(CS_GAP - 1));
    assign frame_last = (frame_cnt == 4'(NUM_CH));
    assign frame_end  = (state == FRAME) && (bit_cnt == 4'd15);
    // A request landing on the last gap cycle of a scan chains straight into the next scan.
    assign start      = sample && ((state == IDLE) || ((state == GAP) && gap_last && frame_last));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            frame_cnt <= 4'd0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_nxt;
            frame_cnt <= frame_nxt;
            gap_cnt   <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FRAME;
            FRAME:   if (bit_cnt == 4'd15) state_nxt = GAP;
            GAP:     if (gap_last) state_nxt = (!frame_last || start) ? FRAME : IDLE;
            default: state_nxt = IDLE;
        endcase
        bit_nxt   = ((state == FRAME) && (bit_cnt != 4'd15)) ? bit_cnt + 4'd1 : 4'd0;
        gap_nxt   = ((state == GAP) && !gap_last) ? gap_cnt + GAP_W'(1) : '0;
        frame_nxt = frame_cnt;
        if (start)
            frame_nxt = 4'd0;
        else if ((state == GAP) && gap_last && !frame_last)
            frame_nxt = frame_cnt + 4'd1;
    end

    // Frame k carries result k-1; frame 0 is the pipeline-priming dummy and frame NUM_CH re-addresses 0.
    always_comb begin
        addr_nxt = (frame_nxt == 4'(NUM_CH)) ? 3'd0 : frame_nxt[2:0];
        word_nxt = ctl_word(addr_nxt);
        cs_n_nxt = (state_nxt != FRAME);
        sdo_nxt  = (state_nxt == FRAME) ? word_nxt[4'd15 - bit_nxt] : 1'b0;
        busy_nxt = (state_nxt != IDLE);
        beat     = frame_end && (frame_cnt != 4'd0);
        chan     = 3'(frame_cnt - 4'd1);
        rx_full  = {rx, sdi};
        ovr_now  = sample && (state != IDLE) && !start;
`ifdef ADC_SCAN_ADDR_CHECK_EN
        mismatch = (rx_full[14:12] != chan);
`else
        mismatch = 1'b0;
`endif
    end

    // ast_source_valid is a one-cycle strobe with no ready: the sink must take every beat,
    // and data/channel/error are meaningful only while valid is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n               <= 1'b1;
            sdo                <= 1'b0;
            busy               <= 1'b0;
            rx                 <= '0;
            ovr_flag           <= 1'b0;
            ast_source_valid   <= 1'b0;
            ast_source_data    <= '0;
            ast_source_channel <= 3'd0;
            ast_source_error   <= 2'b00;
        end else begin
            cs_n             <= cs_n_nxt;
            sdo              <= sdo_nxt;
            busy             <= busy_nxt;
            ast_source_valid <= beat;
            if (state == FRAME)
                rx <= rx_full[RX_W-1:0];
            if (beat) begin
                ast_source_data    <= rx_full[DATA_W-1:0];
                ast_source_channel <= chan;
                ast_source_error   <= {mismatch, frame_last && (ovr_flag || ovr_now)};
            end
            if (beat && frame_last)
                ovr_flag <= 1'b0;
            else if (ovr_now)
                ovr_flag <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_scan_serial.sv
// Bench for adc_scan_serial: a 4-channel and a 1-channel/8-bit instance, each driven by
// a behavioural ADC model, with beats scored against a spec-level expected queue.
module tb_adc_scan_serial;
    localparam int EXP_W = 17;

    typedef struct packed {
        int         cyc;
        logic [1:0] err;
        logic [2:0] ch;
        logic [11:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sample4 = 1'b0, sample1 = 1'b0;
    logic [1:0]  sdi_v = 2'b00;
    logic        sdo4, sdo1, cs4, cs1, valid4, valid1, busy4, busy1;
    logic [11:0] data4;
    logic [7:0]  data1;
    logic [2:0]  ch4, ch1;
    logic [1:0]  err4, err1;
    logic [1:0]  cs_v, sdo_v;
    assign cs_v  = {cs1, cs4};
    assign sdo_v = {sdo1, sdo4};

    adc_scan_serial dut4 (
        .clk(clk), .reset_n(reset_n), .sample(sample4), .sdi(sdi_v[0]), .sdo(sdo4), .cs_n(cs4),
        .ast_source_data(data4), .ast_source_channel(ch4), .ast_source_valid(valid4),
        .ast_source_error(err4), .busy(busy4)
    );

    adc_scan_serial #(.NUM_CH(1), .DATA_W(8), .CS_GAP(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .sample(sample1), .sdi(sdi_v[1]), .sdo(sdo1), .cs_n(cs1),
        .ast_source_data(data1), .ast_source_channel(ch1), .ast_source_valid(valid1),
        .ast_source_error(err1), .busy(busy1)
    );

    int n_checks = 0;
    int n_pass = 0;

    logic [11:0]      code_tab [8] = '{default: 12'h0};
    int               bad_ch = -1;
    logic [15:0]      ctl_q [$];
    logic [EXP_W-1:0] exp_q [$];
    beat_t            beats4 [$];
    beat_t            beats1 [$];
    int               busy4_cnt = 0;
    int               busy1_cnt = 0;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_ctl(input int ch);
        logic [2:0] a;
        a = 3'(ch);
        return {1'b1, 1'b0, 1'b0, a, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
    endfunction

    function automatic logic [15:0] adc_word(input logic [15:0] ctl);
        logic [2:0] a;
        a = ctl[12:10];
        return {1'b0, (int'(a) == bad_ch) ? 3'd5 : a, code_tab[a]};
    endfunction

    task automatic expect_scan(input int nch, input int dw, input bit ovr);
        logic [11:0] d;
        logic        e1;
        for (int c = 0; c < nch; c++) begin
            d  = code_tab[c] & ((12'h1 << dw) - 12'h1);
            e1 = 1'b0;
`ifdef ADC_SCAN_ADDR_CHECK_EN
            e1 = (c == bad_ch);
`endif
            exp_q.push_back({e1, ovr && (c == nch - 1), 3'(c), d});
        end
    endtask

    function automatic beat_t mk_beat(input int c, input logic [1:0] e, input logic [2:0] ch,
                                      input logic [11:0] d);
        beat_t b;
        b.cyc = c; b.err = e; b.ch = ch; b.data = d;
        return b;
    endfunction

    // ADC: shifts DIN in, returns the previous frame's addressed channel on DOUT.
    int          midx  [2] = '{0, 0};
    logic [15:0] mdin  [2] = '{16'h0, 16'h0};
    logic [15:0] mresp [2] = '{16'h0, 16'h0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!cs_v[d]) begin
                sdi_v[d] <= mresp[d][15 - midx[d]];
                mdin[d]  <= {mdin[d][14:0], sdo_v[d]};
                if (midx[d] == 15) begin
                    midx[d]  <= 0;
                    mresp[d] <= adc_word({mdin[d][14:0], sdo_v[d]});
                    if (d == 0) ctl_q.push_back({mdin[d][14:0], sdo_v[d]});
                end else begin
                    midx[d] <= midx[d] + 1;
                end
            end else begin
                midx[d]  <= 0;
                sdi_v[d] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (valid4) beats4.push_back(mk_beat(cyc, err4, ch4, data4));
        if (valid1) beats1.push_back(mk_beat(cyc, err1, ch1, {4'h0, data1}));
        if (busy4) busy4_cnt <= busy4_cnt + 1;
        if (busy1) busy1_cnt <= busy1_cnt + 1;
    end

    // ---------------- drivers ----------------
    task automatic pulse(input bit which, input int edge_no);
        while (cyc < edge_no - 1) @(negedge clk);
        if (which) sample1 = 1'b1;
        else sample4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample4 = 1'b0;
        sample1 = 1'b0;
    endtask

    task automatic wait_idle(input bit which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!(which ? busy1 : busy4)) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad;
        repeat (3) @(negedge clk);
        n_checks++; if (cs4 !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", cs4); else n_pass++;
        n_checks++; if (sdo4 !== 1'b0) $display("FAIL reset_sdo: got %b want 0", sdo4); else n_pass++;
        n_checks++; if ({busy4, valid4} !== 2'b00) $display("FAIL reset_busy_valid: got %b want 00", {busy4, valid4}); else n_pass++;
        n_checks++; if ({data4, ch4, err4} !== 17'h0) $display("FAIL reset_beat_fields: got %h want 0", {data4, ch4, err4}); else n_pass++;
        reset_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs4 !== 1'b1 || busy4 !== 1'b0 || valid4 !== 1'b0 || cs1 !== 1'b1 || valid1 !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL idle_quiet: %0d bad cycles, want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid();
        beats4.delete();
        pulse(1'b0, cyc + 1);
        repeat (6) @(negedge clk);
        n_checks++; if (cs4 !== 1'b0) $display("FAIL mid_frame_cs_low: got %b want 0", cs4); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (cs4 !== 1'b1) $display("FAIL async_reset_cs: got %b want 1", cs4); else n_pass++;
        n_checks++; if (busy4 !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy4); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++; if (beats4.size() !== 0) $display("FAIL reset_no_beat: got %0d beats want 0", beats4.size()); else n_pass++;
    endtask

    task automatic test_scan4();
        int t, busy0;
        bit ok;
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < 8; c++)
                code_tab[c] = (it == 0) ? 12'(12'h100 + c) : 12'($urandom_range(0, 4095));
            beats4.delete(); ctl_q.delete(); exp_q.delete();
            expect_scan(4, 12, 1'b0);
            busy0 = busy4_cnt;
            t = cyc + 1;
            pulse(1'b0, t);
            wait_idle(1'b0, ok);
            n_checks++; if (!ok) $display("FAIL scan_timeout: busy high after 400 cycles"); else n_pass++;
            n_checks++; if (busy4_cnt - busy0 !== 90) $display("FAIL scan_busy_len: got %0d want 90", busy4_cnt - busy0); else n_pass++;
            n_checks++; if (beats4.size() !== 4) $display("FAIL scan_beat_count: got %0d want 4", beats4.size()); else n_pass++;
            for (int i = 0; i < 4 && i < beats4.size(); i++) begin
                n_checks++;
                if ({beats4[i].err, beats4[i].ch, beats4[i].data} !== exp_q[i])
                    $display("FAIL scan_beat%0d: got %h want %h", i, {beats4[i].err, beats4[i].ch, beats4[i].data}, exp_q[i]);
                else n_pass++;
                n_checks++;
                if (beats4[i].cyc - t !== 34 + 18 * i)
                    $display("FAIL scan_beat%0d_time: got +%0d want +%0d", i, beats4[i].cyc - t, 34 + 18 * i);
                else n_pass++;
            end
            n_checks++; if (ctl_q.size() !== 5) $display("FAIL ctl_count: got %0d want 5", ctl_q.size()); else n_pass++;
            for (int k = 0; k < 5 && k < ctl_q.size(); k++) begin
                n_checks++;
                if (ctl_q[k] !== ref_ctl(k % 4)) $display("FAIL ctl_frame%0d: got %h want %h", k, ctl_q[k], ref_ctl(k % 4));
                else n_pass++;
            end
        end
    endtask

    task automatic test_overrun();
        int t, busy0;
        bit ok;
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            for (int c = 0; c < 8; c++) code_tab[c] = 12'($urandom_range(0, 4095));
            beats4.delete(); exp_q.delete();
            expect_scan(4, 12, pass_no == 0);
            busy0 = busy4_cnt;
            t = cyc + 1;
            pulse(1'b0, t);
            if (pass_no == 0) pulse(1'b0, t + 40);
            wait_idle(1'b0, ok);
            n_checks++; if (!ok) $display("FAIL ovr_timeout: busy high after 400 cycles"); else n_pass++;
            n_checks++; if (busy4_cnt - busy0 !== 90) $display("FAIL ovr_busy_len: got %0d want 90", busy4_cnt - busy0); else n_pass++;
            n_checks++; if (beats4.size() !== 4) $display("FAIL ovr_beat_count: got %0d want 4", beats4.size()); else n_pass++;
            for (int i = 0; i < 4 && i < beats4.size(); i++) begin
                n_checks++;
                if ({beats4[i].err, beats4[i].ch, beats4[i].data} !== exp_q[i])
                    $display("FAIL ovr_pass%0d_beat%0d: got %h want %h", pass_no, i, {beats4[i].err, beats4[i].ch, beats4[i].data}, exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_addr_check();
        int t;
        bit ok;
        for (int c = 0; c < 8; c++) code_tab[c] = 12'($urandom_range(0, 4095));
        bad_ch = 1;
        beats4.delete(); exp_q.delete();
        expect_scan(4, 12, 1'b0);
        t = cyc + 1;
        pulse(1'b0, t);
        wait_idle(1'b0, ok);
        n_checks++; if (!ok) $display("FAIL addr_timeout: busy high after 400 cycles"); else n_pass++;
        n_checks++; if (beats4.size() !== 4) $display("FAIL addr_beat_count: got %0d want 4", beats4.size()); else n_pass++;
        for (int i = 0; i < 4 && i < beats4.size(); i++) begin
            n_checks++;
            if ({beats4[i].err, beats4[i].ch, beats4[i].data} !== exp_q[i])
                $display("FAIL addr_beat%0d: got %h want %h", i, {beats4[i].err, beats4[i].ch, beats4[i].data}, exp_q[i]);
            else n_pass++;
        end
        bad_ch = -1;
    endtask

    task automatic test_single_channel();
        int t, busy0;
        bit ok;
        for (int c = 0; c < 8; c++) code_tab[c] = 12'($urandom_range(0, 4095));
        beats1.delete(); exp_q.delete();
        for (int s = 0; s < 3; s++) expect_scan(1, 8, 1'b0);
        busy0 = busy1_cnt;
        t = cyc + 1;
        pulse(1'b1, t);
        pulse(1'b1, t + 36);
        pulse(1'b1, t + 72);
        wait_idle(1'b1, ok);
        n_checks++; if (!ok) $display("FAIL ch1_timeout: busy high after 400 cycles"); else n_pass++;
        n_checks++; if (busy1_cnt - busy0 !== 108) $display("FAIL ch1_busy_len: got %0d want 108", busy1_cnt - busy0); else n_pass++;
        n_checks++; if (beats1.size() !== 3) $display("FAIL ch1_beat_count: got %0d want 3", beats1.size()); else n_pass++;
        for (int i = 0; i < 3 && i < beats1.size(); i++) begin
            n_checks++;
            if ({beats1[i].err, beats1[i].ch, beats1[i].data} !== exp_q[i])
                $display("FAIL ch1_beat%0d: got %h want %h", i, {beats1[i].err, beats1[i].ch, beats1[i].data}, exp_q[i]);
            else n_pass++;
            n_checks++;
            if (beats1[i].cyc - t !== 34 + 36 * i)
                $display("FAIL ch1_beat%0d_time: got +%0d want +%0d", i, beats1[i].cyc - t, 34 + 36 * i);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_scan4();
        test_overrun();
        test_addr_check();
        test_single_channel();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adc_scan_serial.md
# adc_scan_serial

Multi-channel successor to the single-channel ADC serial front end. On each `sample` pulse it runs one scan of `NUM_CH` channels of an AD7928-class 16-bit-frame SPI ADC and emits one Avalon-ST beat per channel, tagged with a channel number, for the lowpass/highpass filter banks and the DAC path. It sits between `sample_divider` and the filters, clocked by `clk_20`, which is also forwarded to the ADC as SCLK.

## Interface
Parameters:
- `NUM_CH`, 4: channels per scan, 1..8; addresses 0..NUM_CH-1.
- `DATA_W`, 12: output sample width, 1..12; the LSBs of the returned 12-bit code.
- `CS_GAP`, 2: cycles `cs_n` is held high between frames, at least 1.

Ports:
- `clk` in 1: system and serial clock (`clk_20`).
- `reset_n` in 1: asynchronous, active-low reset.
- `sample` in 1: one-cycle scan request.
- `sdi` in 1: ADC DOUT.
- `sdo` out 1: ADC DIN (control word).
- `cs_n` out 1: ADC chip select, active low.
- `ast_source_data` out DATA_W: conversion result.
- `ast_source_channel` out 3: channel of the current beat.
- `ast_source_valid` out 1: one-cycle beat strobe.
- `ast_source_error` out 2: [0] overrun, [1] address mismatch.
- `busy` out 1: high from scan start to end of the final gap.

## Operation
- States: IDLE, FRAME, GAP.
  - IDLE goes to FRAME on `sample`.
  - FRAME lasts 16 cycles, then goes to GAP.
  - GAP lasts CS_GAP cycles, then goes to FRAME if frames remain, otherwise to IDLE.
- A scan is NUM_CH+1 frames, k = 0..NUM_CH.
  - Frame k sends address (k mod NUM_CH). The last frame re-addresses channel 0.
  - The ADC pipelines by one frame, so the result returned in frame k belongs to channel k-1.
  - Frame 0's returned data is discarded and produces no beat.
- Control word, MSB first:
  - WRITE=1, SEQ=0, 0, ADD[2:0], PM=11, SHADOW=0, 0, RANGE=0, CODING=1, 0000.
  - Channel 2 therefore gives 16'h8B10.
- Returned frame, MSB first: bit15=0, ADD[14:12], code[11:0]. `ast_source_data` = code[DATA_W-1:0].
- Error bits:
  - error[0] (overrun): a `sample` arriving while `busy` is ignored and sets a sticky flag. The flag is reported on the last beat of the current scan, then cleared.
  - error[1] (mismatch): set on a beat whose returned ADD differs from the expected channel k-1.
- Reset values: `cs_n`=1, `sdo`=0, `busy`=0, `ast_source_valid`=0, data/channel/error=0.
- Reset mid-scan: `cs_n` goes high immediately and no beat is emitted. After release the block is in IDLE and the next `sample` starts a fresh scan that includes the dummy frame.

## Timing
- All outputs are registered on the rising edge of `clk`.
- `sample` high at edge t: `cs_n` low for cycles t+1..t+16.
- `sdo` presents bit (16-i) of the control word during cycle t+i.
- `sdi` is sampled at the edge ending each cs_n-low cycle. Bit 15 is sampled at the end of cycle t+1, bit 0 at the end of cycle t+16.
- A beat's `ast_source_valid` is high for exactly one cycle: the first GAP cycle after its frame. Data, channel and error are stable and qualified by valid only.
- Frame period: 16+CS_GAP cycles. Scan length: (NUM_CH+1)*(16+CS_GAP) cycles.
  - The defaults give 90 cycles (4.5 µs at 20 MHz).
  - The `sample` period must exceed the scan length, otherwise overrun is flagged.
- `busy` falls in the cycle after the final GAP cycle. A `sample` in that same cycle starts a new scan and is not an overrun.
- There is no backpressure: the sink must accept every beat.

## Configuration
- `ADC_SCAN_ADDR_CHECK_EN` defined: address comparison is compiled in and error[1] operates as specified.
- Not defined: the comparator and returned-address storage are removed, and error[1] is tied to 0.
- error[0] is unaffected in both cases.

## Test plan
- Reset, then idle 50 cycles: `cs_n`=1, `busy`=0, no valid. Assert `reset_n` low mid-frame: `cs_n` goes high asynchronously.
- NUM_CH=4, CS_GAP=2, ADC model returns channel c code 12'h100+c:
  - one `sample` gives exactly 4 beats, channels 0,1,2,3, data 12'h100..12'h103;
  - beats are 18 cycles apart and the first valid is at t+35;
  - `busy` is high for 90 cycles.
- Control-word check: frame 2's `sdo` bits shift out 16'h8B10; frame 4 sends 16'h8310.
- Overrun: second `sample` 40 cycles after the first: no second scan starts, the channel 3 beat has error=2'b01, and the next scan is clean.
- With `ADC_SCAN_ADDR_CHECK_EN`, the model returns ADD=5 for channel 1: that beat has error[1]=1 and the other beats 0. Without the macro, error[1]=0 throughout.
- NUM_CH=1, DATA_W=8: 2 frames and 1 beat per scan, channel 0, data = code[7:0]; back-to-back `sample` exactly at the 36-cycle period gives no overrun.
